// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - Shared FSM state type and default word width for the frame serializer
package serial_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/serializador_quadro_contador_bits.sv
// rtl/serializador_quadro_contador_bits.sv - Saturating data-bit counter with load, enable and terminal count
module contador_bits #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  assign terminal = (count == LAST);

  // Holds at the last bit index so the count cannot wrap inside a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serializador_quadro.sv
// rtl/serializador_quadro.sv - LSB-first word serializer; SERIALIZADOR_PARIDADE_EN appends an even-parity bit
module serializador_quadro
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              out_bit,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state, state_next;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   count;
  logic               terminal;
  logic               accept;
  logic               shifting;

  assign accept   = (state == IDLE) && valid_in;
  assign shifting = (state == SHIFT);

  contador_bits #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_contador (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .enable   (shifting),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        shreg <= data_in;
      end else if (shifting) begin
        shreg <= shreg >> 1;
      end
    end
  end

`ifdef SERIALIZADOR_PARIDADE_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      parity <= 1'b0;
    end else if (shifting) begin
      parity <= parity ^ shreg[0];
    end
  end
`endif

  always_comb begin
    state_next  = state;
    ready_out   = 1'b0;
    out_bit     = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_next = SHIFT;
      end
      SHIFT: begin
        out_bit     = shreg[0];
        bit_valid   = 1'b1;
        frame_start = (count == '0);
        if (terminal) begin
`ifdef SERIALIZADOR_PARIDADE_EN
          state_next = PARITY;
`else
          state_next = IDLE;
          done       = 1'b1;
`endif
        end
      end
`ifdef SERIALIZADOR_PARIDADE_EN
      PARITY: begin
        out_bit    = parity;
        bit_valid  = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serializador_quadro.sv
// tb/tb_serializador_quadro.sv - Directed and random frame checks against a word-level reference model
module tb_serializador_quadro;

  localparam int DATA_W = 8;
`ifdef SERIALIZADOR_PARIDADE_EN
  localparam int  FRAME  = DATA_W + 1;
  localparam bit  PAR_ON = 1'b1;
`else
  localparam int  FRAME  = DATA_W;
  localparam bit  PAR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              out_bit;
  logic              bit_valid;
  logic              frame_start;
  logic              done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serializador_quadro #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .out_bit     (out_bit),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: data bits LSB first, then popcount parity when enabled.
  function automatic logic ref_bit(input logic [DATA_W-1:0] w, input int i);
    if (i < DATA_W) return (w >> i) & 1;
    return logic'($countones(w) % 2);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready_out, 1);
    check({tag, "_bv"}, bit_valid, 0);
    check({tag, "_bit"}, out_bit, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Called in an IDLE cycle; leaves the bench in the IDLE cycle after the frame.
  task automatic send_word(input string tag, input logic [DATA_W-1:0] w, input bit busy_hold);
    logic ds_par;
    check({tag, "_rdy_pre"}, ready_out, 1);
    data_in  = w;
    valid_in = 1'b1;
    step();
    ds_par = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (busy_hold) data_in = DATA_W'($urandom);
      else valid_in = 1'b0;
      check($sformatf("%s_bit%0d", tag, i), out_bit, ref_bit(w, i));
      check($sformatf("%s_bv%0d", tag, i), bit_valid, 1);
      check($sformatf("%s_fs%0d", tag, i), frame_start, (i == 0));
      check($sformatf("%s_done%0d", tag, i), done, (i == FRAME - 1));
      check($sformatf("%s_rdy%0d", tag, i), ready_out, 0);
      ds_par = frame_start ? out_bit : (ds_par ^ out_bit);
      step();
    end
    if (PAR_ON) check({tag, "_downstream_par"}, ds_par, 0);
    check_idle({tag, "_gap"});
    if (!busy_hold) valid_in = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post_reset");

    send_word("a5", 8'hA5, 1'b0);
    step();
    send_word("07", 8'h07, 1'b0);
    step();
    send_word("ff", 8'hFF, 1'b0);
    step();
    check_idle("ff_idle2");

    // Valid held high with changing data while busy; next word taken after one IDLE gap.
    send_word("busy1", 8'h5A, 1'b1);
    send_word("busy2", 8'hC3, 1'b0);
    step();

    // Reset on the 4th bit of 0x3C aborts the frame without done.
    data_in  = 8'h3C;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_bit%0d", i), out_bit, ref_bit(8'h3C, i));
      check($sformatf("abort_done%0d", i), done, 0);
      if (i == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    check_idle("abort_after");
    step();
    check_idle("abort_after2");
    send_word("01", 8'h01, 1'b0);
    step();

    // Reset wins over a simultaneous handshake; the word is dropped.
    data_in  = 8'h55;
    valid_in = 1'b1;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    valid_in = 1'b0;
    check_idle("rst_prio");
    step();
    check_idle("rst_prio2");

    for (int n = 0; n < 6; n++) begin
      send_word($sformatf("rnd%0d", n), DATA_W'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
